rld_out_queue: RTL and testbench

Per-queue output stage placed directly downstream of the RLDRAM read arbiter, with one instance per queue.
- Accepts one slice of the arbiter's per-queue `dout`/`dout_valid` bus and buffers the words in an on-chip FIFO.
- Re-forms the words into an AXI4-Stream master interface for the queue's output port.
- Drives the `full` back-pressure bit the arbiter uses to stop issuing read bursts for this queue.

---
 rtl/rld_pkg.sv | 38 +++
 rtl/rld_sync_fifo.sv | 47 ++++
 rtl/rld_out_queue.sv | 90 +++++++++
 tb/tb_rld_out_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rld_pkg.sv
// Shared definitions for the RLDRAM per-queue output path.
// Word layout on the arbiter bus: [8*TW-1:0] data, [8*TW] last,
// [8*TW+6:8*TW+1] byte count minus 1, top 2 bits reserved.
package rld_pkg;

  localparam int unsigned CNT_W     = 6;
  localparam int unsigned RSVD_W    = 2;
  localparam int unsigned MAX_BYTES = 64;

  // Bit position of the last flag for a given byte width.
  function automatic int unsigned last_bit(input int unsigned tw);
    return 8 * tw;
  endfunction

  // LSB of the byte-count field.
  function automatic int unsigned cnt_lsb(input int unsigned tw);
    return 8 * tw + 1;
  endfunction

  // Full word width including reserved bits.
  function automatic int unsigned word_w(input int unsigned tw);
    return 8 * tw + 1 + CNT_W + RSVD_W;
  endfunction

  // Byte enables: all valid bytes for non-last beats, low (cnt+1) bytes
  // on the last beat; counts at or beyond the bus width saturate.
  function automatic logic [MAX_BYTES-1:0] tkeep_decode(input logic             last,
                                                        input logic [CNT_W-1:0] cnt,
                                                        input int unsigned      nbytes);
    logic [MAX_BYTES-1:0] keep;
    keep = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      keep[i] = (i < nbytes) && (!last || (i <= 32'(cnt)));
    end
    return keep;
  endfunction

endpackage

// File: rtl/rld_sync_fifo.sv
// Single-clock RAM FIFO with registered read port.
// Ports: clk, reset (sync, active high), wr_en/wr_data, rd_en/rd_data
// (rd_data valid the cycle after rd_en and held until the next rd_en),
// count (entries stored). Caller never writes when full or reads when empty.
module rld_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_en) begin
        rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
        rd_data <= mem[rd_ptr];
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/rld_out_queue.sv
// Per-queue output stage behind the RLDRAM read arbiter: buffers words in a
// FIFO and presents them as an AXI4-Stream master.
// Ports: clk, reset (sync, active high); din_valid/din from the arbiter;
// full back-pressure to the arbiter; m_axis_* stream master; fill_level
// (FIFO entries, excluding the output register); overflow (sticky drop flag).
module rld_out_queue
  import rld_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned FULL_SLACK  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        din_valid,
  input  logic [8*TDATA_WIDTH+8:0]    din,
  output logic                        full,
  output logic [8*TDATA_WIDTH-1:0]    m_axis_tdata,
  output logic [TDATA_WIDTH-1:0]      m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DEPTH_LOG2:0]         fill_level,
  output logic                        overflow
);

  localparam int unsigned DW          = 8 * TDATA_WIDTH;
  localparam int unsigned WW          = word_w(TDATA_WIDTH);
  localparam int unsigned LAST_BIT    = last_bit(TDATA_WIDTH);
  localparam int unsigned CNT_LSB     = cnt_lsb(TDATA_WIDTH);
  localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
  localparam int unsigned CW          = DEPTH_LOG2 + 1;
  localparam int unsigned FW          = DW + 1 + TDATA_WIDTH;
  localparam int unsigned FULL_THRESH = DEPTH - FULL_SLACK;

  logic                   fifo_full;
  logic                   wr_en;
  logic                   load;
  logic [CW-1:0]          count_next;
  logic [TDATA_WIDTH-1:0] keep_in;
  logic [FW-1:0]          fifo_wdata;
  logic [FW-1:0]          fifo_rdata;
  logic                   unused_rsvd;

  // Reserved header bits carry no meaning here.
  assign unused_rsvd = ^din[WW-1 -: RSVD_W];

  assign fifo_full  = (fill_level == CW'(DEPTH));
  assign wr_en      = din_valid && !fifo_full;
  assign load       = (fill_level != '0) && (!m_axis_tvalid || m_axis_tready);
  assign count_next = fill_level + CW'(wr_en) - CW'(load);

  // Decode tkeep before storage so the stream outputs come straight from flops.
  assign keep_in    = TDATA_WIDTH'(tkeep_decode(din[LAST_BIT], din[CNT_LSB +: CNT_W], TDATA_WIDTH));
  assign fifo_wdata = {keep_in, din[LAST_BIT], din[DW-1:0]};

  // The FIFO read register doubles as the show-ahead output register.
  rld_sync_fifo #(
    .WIDTH      (FW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (fifo_wdata),
    .rd_en   (load),
    .rd_data (fifo_rdata),
    .count   (fill_level)
  );

  assign m_axis_tdata = fifo_rdata[DW-1:0];
  assign m_axis_tlast = fifo_rdata[DW];
  assign m_axis_tkeep = fifo_rdata[FW-1 -: TDATA_WIDTH];

  // Stream valid, back-pressure and overflow flags.
  // full is registered from the next count so it tracks fill_level exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      full          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (load)               m_axis_tvalid <= 1'b1;
      else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      full <= (count_next >= CW'(FULL_THRESH));
      if (din_valid && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rld_out_queue.sv
module tb_rld_out_queue;

  localparam int unsigned TW = 32;
  localparam int unsigned DW = 8 * TW;
  localparam int unsigned WW = DW + 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          din_valid;
  logic [WW-1:0] din;
  logic          full;
  logic [DW-1:0] tdata;
  logic [TW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [6:0]    fill_level;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rld_out_queue #(
    .TDATA_WIDTH (TW),
    .DEPTH_LOG2  (6),
    .FULL_SLACK  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .din_valid     (din_valid),
    .din           (din),
    .full          (full),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .fill_level    (fill_level),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int i);
    return {8{32'(i) ^ 32'hC3C3_0000}};
  endfunction

  // Reserved bits driven to ones; the block must ignore them.
  function automatic logic [WW-1:0] mkw(input logic [DW-1:0] d, input logic last, input int cnt);
    return {2'b11, 6'(cnt), last, d};
  endfunction

  function automatic logic [TW-1:0] exp_keep(input logic last, input int cnt);
    if (!last || cnt >= 31) return '1;
    return TW'((64'd1 << (cnt + 1)) - 64'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    tick();
    reset     = 1'b0;
  endtask

  initial begin
    int e, rcv, sent;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic [TW-1:0] prev_keep;

    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    tready    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_tvalid", DW'(tvalid), '0);
    check("rst_tdata", tdata, '0);
    check("rst_tkeep", DW'(tkeep), '0);
    check("rst_tlast", DW'(tlast), '0);
    check("rst_fill", DW'(fill_level), '0);
    check("rst_full", DW'(full), '0);
    check("rst_ovf", DW'(overflow), '0);

    // Single word, two-cycle latency.
    din       = mkw({32{8'hA5}}, 1'b1, 3);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("t1_fill_n", DW'(fill_level), DW'(1));
    check("t1_tvalid_n", DW'(tvalid), '0);
    tick();
    check("t1_tvalid", DW'(tvalid), DW'(1));
    check("t1_tkeep", DW'(tkeep), DW'(32'h0000_000F));
    check("t1_tlast", DW'(tlast), DW'(1));
    check("t1_tdata", tdata, {32{8'hA5}});
    check("t1_fill", DW'(fill_level), '0);
    tready = 1'b1;
    tick();
    check("t1_tvalid_drop", DW'(tvalid), '0);
    tready = 1'b0;

    // Fill with output stalled: full at 48, storage up to 64.
    for (int k = 0; k <= 64; k++) begin
      din       = mkw(dat(k), 1'b0, 0);
      din_valid = 1'b1;
      tick();
      e = (k == 0) ? 1 : k;
      check("fill_lvl", DW'(fill_level), DW'(e));
      check("fill_full", DW'(full), DW'(e >= 48));
      check("fill_ovf", DW'(overflow), '0);
    end
    din = mkw(dat(999), 1'b1, 0);
    tick();
    din_valid = 1'b0;
    check("ovf_set", DW'(overflow), DW'(1));
    check("ovf_fill", DW'(fill_level), DW'(64));
    check("ovf_hold_valid", DW'(tvalid), DW'(1));
    check("ovf_hold_data", tdata, dat(0));

    // Drain; the dropped word must not appear.
    tready = 1'b1;
    rcv    = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (tvalid) begin
        check("drain_data", tdata, dat(rcv));
        rcv++;
      end
      tick();
      if (!tvalid && rcv >= 65) break;
    end
    check("drain_count", DW'(rcv), DW'(65));
    check("drain_fill", DW'(fill_level), '0);
    check("drain_ovf_sticky", DW'(overflow), DW'(1));

    do_reset();
    check("rst2_ovf", DW'(overflow), '0);
    check("rst2_fill", DW'(fill_level), '0);

    // 200 words with tready toggling; writer respects full.
    tready     = 1'b0;
    rcv        = 0;
    sent       = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_keep  = '0;
    for (int cyc = 0; cyc < 3000 && rcv < 200; cyc++) begin
      if (prev_stall) begin
        check("stall_valid", DW'(tvalid), DW'(1));
        check("stall_data", tdata, prev_data);
        check("stall_keep", DW'(tkeep), DW'(prev_keep));
      end
      tready = ~tready;
      if (tvalid) begin
        check("wrap_data", tdata, dat(1000 + rcv));
        check("wrap_keep", DW'(tkeep), DW'(exp_keep(rcv % 4 == 3, rcv % 40)));
        check("wrap_last", DW'(tlast), DW'(rcv % 4 == 3));
        if (tready) rcv++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_keep  = tkeep;
      din_valid  = (sent < 200) && !full;
      if (din_valid) begin
        din = mkw(dat(1000 + sent), sent % 4 == 3, sent % 40);
        sent++;
      end
      tick();
    end
    din_valid = 1'b0;
    check("wrap_count", DW'(rcv), DW'(200));
    check("wrap_ovf", DW'(overflow), '0);

    // Concurrent write and read hold the level at 10.
    do_reset();
    tready = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      din       = mkw(dat(2000 + k), 1'b0, 0);
      din_valid = 1'b1;
      tick();
    end
    check("steady_start", DW'(fill_level), DW'(10));
    tready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      din       = mkw(dat(2011 + j), 1'b0, 0);
      din_valid = 1'b1;
      tick();
      check("steady_fill", DW'(fill_level), DW'(10));
      check("steady_data", tdata, dat(2001 + j));
    end
    din_valid = 1'b0;

    // Reset with 30 words stored, then a fresh packet.
    do_reset();
    tready = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      din       = mkw(dat(2500 + k), 1'b0, 0);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    check("mid_fill", DW'(fill_level), DW'(30));
    check("mid_full", DW'(full), '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_tvalid", DW'(tvalid), '0);
    check("mid_rst_fill", DW'(fill_level), '0);
    check("mid_rst_full", DW'(full), '0);
    check("mid_rst_ovf", DW'(overflow), '0);
    check("mid_rst_tdata", tdata, '0);
    for (int k = 0; k < 3; k++) begin
      din       = mkw(dat(3000 + k), k == 2, (k == 2) ? 5 : 0);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tready    = 1'b1;
    rcv       = 0;
    for (int cyc = 0; cyc < 50 && rcv < 4; cyc++) begin
      if (tvalid) begin
        check("pkt_data", tdata, dat(3000 + rcv));
        check("pkt_keep", DW'(tkeep), DW'((rcv == 2) ? 32'h0000_003F : 32'hFFFF_FFFF));
        check("pkt_last", DW'(tlast), DW'(rcv == 2));
        rcv++;
      end
      tick();
      if (!tvalid && rcv >= 3) break;
    end
    check("pkt_count", DW'(rcv), DW'(3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
